control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Controller FSM directly upstream of the datapath. Takes IRout and status and drives all datapath strobes/selects.
//  Sequences fetch (IF1/IF2/UPDATE_PC), decode and per-instruction execute for the simple RISC ISA.
//  Sign-extends the immediates and selects readnum/writenum from the IR fields.
// PARAMETERS
//  LINK_REG  3'd7  register written by BL/BLX with the return PC
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-low (0 = reset); forces state S_RST
//  IRout     in   16  instruction register from the datapath
//  status    in   3   {Z,N,V} flags from the datapath
//  readnum   out  3   register-file read select
//  writenum  out  3   register-file write select
//  write     out  1   register-file write enable
//  loada, loadb, loadc, loads, loadir  out 1 each  datapath load enables
//  asel, bsel, msel, mwrite, incp, execb, tsel  out 1 each  datapath selects
//  shift     out  2   IR[4:3]; forced to 00 in S_STW
//  ALUop     out  2   IR[12:11]; forced to 00 in S_ADDR
//  vsel      out  2   11=mdata, 10=sximm8, 01=PC, 00=C
//  cond      out  3   IR[10:8] in S_BR; 3'b111 (always) in S_BRX and for BL
//  sximm5    out  16  sign-extended IR[4:0]
//  sximm8    out  16  sign-extended IR[7:0]
//  pcreset   out  1   drives the datapath PC reset mux; 1 only in S_RST
//  halted    out  1   1 in S_HALT
// BEHAVIOUR
//  - Moore FSM; all strobes are decoded from state only; the default for every strobe is 0.
//  - Asynchronous reset (reset=0) enters S_RST at any time, including mid-instruction.
//  - In S_RST only pcreset=1, so PC<=0 on each edge held in reset. The first edge after release goes to IF1.
//  - Fetch path:
//    - IF1: msel=0.
//    - IF2: msel=0, loadir=1.
//    - UPC: incp=1 (PC<=PC+1).
//    - DEC: no strobes; branches on opcode IR[15:13] and op IR[12:11].
//  - MOV imm (110/10): WIMM (vsel=10, writenum=Rn, write). Total 5 cycles.
//  - MOV reg (110/00): GETB -> ALU (asel=1) -> WR. Total 7 cycles.
//  - ADD/CMP/AND/MVN (101/xx): GETA -> GETB -> ALU -> WR. Total 8 cycles; CMP skips WR (7 cycles).
//    - GETA: readnum=Rn, loada.
//    - GETB: readnum=Rm, loadb.
//    - ALU: loadc; loads=1 only for CMP.
//    - WR: vsel=00, writenum=Rd, write.
//  - LDR (011/00): GETA -> ADDR -> MEM -> LDW. Total 8 cycles.
//    - ADDR: bsel=1, ALUop=00, loadc.
//    - MEM: msel=1 (RAM samples address).
//    - LDW: msel=1, vsel=11, writenum=Rd, write.
//  - STR (100/00): GETA -> ADDR -> GETD -> STW. Total 8 cycles.
//    - GETD: readnum=Rd, loadb.
//    - STW: msel=1, mwrite=1.
//  - B<cond> (001/00): BR (execb=1, tsel=1, cond=IR[10:8]). Total 5 cycles.
//    - PC<=PC+sximm8 if taken, else PC is unchanged (already incremented in UPC).
//  - BL (010/11): LINK (vsel=01, writenum=LINK_REG, write) -> BR with cond=111. Total 6 cycles.
//  - BX (010/00): GETA (readnum=Rd) -> BRX (execb=1, tsel=0, cond=111). Total 6 cycles.
//  - BLX (010/10): GETA(Rd) -> LINK -> BRX. Total 7 cycles.
//    - Rd is read before the link write, so BLX R7 jumps to the old R7.
//  - HALT (111/xx) and any undefined opcode/op go to S_HALT. S_HALT drives no strobes and is left only via reset.
//  - Every execute sequence returns to IF1. PC wraps 8'hFF->8'h00 (handled in the datapath).
//  - Field map: Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0].
//  - readnum/writenum outside the states listed above = 3'b000.
// STRUCTURE
//  - State encodings (5-bit), opcode/op constants and vsel codes go in the shared `define file control_defs.vh.
//  - Sub-module instr_decoder: purely combinational.
//    - IR -> opcode, op, Rn, Rd, Rm, shift, sximm5, sximm8.
//  - The top level holds the state register plus next-state and output decode.
// TESTING
//  - Reset: hold reset=0 for 3 edges -> pcreset=1, all strobes 0; release -> IF1 on the next edge.
//  - MOV R3,#-2: IR=16'hD3FE -> WIMM: writenum=3, vsel=10, sximm8=16'hFFFE, write=1; back in IF1 5 cycles after IF1.
//  - CMP R1,R2 (16'hA902): loads=1 in ALU, write never asserted; 7 cycles.
//  - STR/LDR: IR=16'h8041 -> STW: mwrite=1, msel=1.
//  - STR/LDR: IR=16'h6041 -> LDW: vsel=11, writenum=2, write=1.
//  - BLT with status=3'b010 (N=1,V=0), IR=16'h2305 -> BR: execb=1, tsel=1, cond=011.
//  - BLX R7 then HALT: writenum=7 in LINK after the GETA readnum=7; IR=16'hE000 -> halted=1.
//    Then reset=0 mid-S_HALT -> S_RST immediately (asynchronous).

Source files
------------

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the RISC controller: FSM state codes, opcode/op fields,
// writeback select codes and the decoded instruction-field bundle.
package control_fsm_pkg;

    localparam logic [4:0] S_RST  = 5'd0;
    localparam logic [4:0] S_IF1  = 5'd1;
    localparam logic [4:0] S_IF2  = 5'd2;
    localparam logic [4:0] S_UPC  = 5'd3;
    localparam logic [4:0] S_DEC  = 5'd4;
    localparam logic [4:0] S_WIMM = 5'd5;
    localparam logic [4:0] S_GETA = 5'd6;
    localparam logic [4:0] S_GETB = 5'd7;
    localparam logic [4:0] S_ALU  = 5'd8;
    localparam logic [4:0] S_WR   = 5'd9;
    localparam logic [4:0] S_ADDR = 5'd10;
    localparam logic [4:0] S_MEM  = 5'd11;
    localparam logic [4:0] S_LDW  = 5'd12;
    localparam logic [4:0] S_GETD = 5'd13;
    localparam logic [4:0] S_STW  = 5'd14;
    localparam logic [4:0] S_BR   = 5'd15;
    localparam logic [4:0] S_LINK = 5'd16;
    localparam logic [4:0] S_BRX  = 5'd17;
    localparam logic [4:0] S_HALT = 5'd18;

    localparam logic [2:0] OPC_BR  = 3'b001;
    localparam logic [2:0] OPC_BX  = 3'b010;
    localparam logic [2:0] OPC_LDR = 3'b011;
    localparam logic [2:0] OPC_STR = 3'b100;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_ALU_CMP = 2'b01;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_BX      = 2'b00;
    localparam logic [1:0] OP_BLX     = 2'b10;
    localparam logic [1:0] OP_BL      = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] COND_ALWAYS = 3'b111;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  op;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [2:0]  rm;
        logic [1:0]  shift;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } ir_fields_t;

endpackage

// File: rtl/control_fsm_if.sv
// Controller <-> datapath bundle: instruction/flags in, strobes and selects out.
interface control_fsm_if;
    logic [15:0] IRout;
    logic [2:0]  status;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada, loadb, loadc, loads, loadir;
    logic        asel, bsel, msel, mwrite, incp, execb, tsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [1:0]  vsel;
    logic [2:0]  cond;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic        pcreset;
    logic        halted;

    modport master (
        input  IRout, status,
        output readnum, writenum, write,
        output loada, loadb, loadc, loads, loadir,
        output asel, bsel, msel, mwrite, incp, execb, tsel,
        output shift, ALUop, vsel, cond, sximm5, sximm8, pcreset, halted
    );

    modport slave (
        output IRout, status,
        input  readnum, writenum, write,
        input  loada, loadb, loadc, loads, loadir,
        input  asel, bsel, msel, mwrite, incp, execb, tsel,
        input  shift, ALUop, vsel, cond, sximm5, sximm8, pcreset, halted
    );
endinterface

// File: rtl/control_fsm_instr_decoder.sv
// Purely combinational split of the instruction register into its fields
// plus the two sign-extended immediates.
module control_fsm_instr_decoder
    import control_fsm_pkg::*;
(
    input  logic [15:0] ir_i,
    output ir_fields_t  fields_o
);

    always_comb begin
        fields_o.opcode = ir_i[15:13];
        fields_o.op     = ir_i[12:11];
        fields_o.rn     = ir_i[10:8];
        fields_o.rd     = ir_i[7:5];
        fields_o.rm     = ir_i[2:0];
        fields_o.shift  = ir_i[4:3];
        fields_o.sximm5 = {{11{ir_i[4]}}, ir_i[4:0]};
        fields_o.sximm8 = {{8{ir_i[7]}}, ir_i[7:0]};
    end

endmodule

// File: rtl/control_fsm.sv
// Moore controller: fetch, decode and per-instruction execute sequencing,
// driving every datapath strobe from the current state.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter logic [2:0] LINK_REG = 3'd7
) (
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
);

    logic [4:0] state_q, state_d;
    ir_fields_t f;
    logic       unused_status;

    // Flags are consumed by the datapath's branch unit, not by this controller.
    assign unused_status = ^bus.status;

    control_fsm_instr_decoder u_instr_decoder (
        .ir_i     (bus.IRout),
        .fields_o (f)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                state_d = S_HALT;
                case (f.opcode)
                    OPC_MOV: begin
                        if (f.op == OP_MOV_IMM)      state_d = S_WIMM;
                        else if (f.op == OP_MOV_REG) state_d = S_GETB;
                    end
                    OPC_ALU: state_d = S_GETA;
                    OPC_LDR, OPC_STR: if (f.op == OP_NONE) state_d = S_GETA;
                    OPC_BR:  if (f.op == OP_NONE) state_d = S_BR;
                    OPC_BX: begin
                        if (f.op == OP_BL)                         state_d = S_LINK;
                        else if (f.op == OP_BX || f.op == OP_BLX) state_d = S_GETA;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_GETA: begin
                case (f.opcode)
                    OPC_ALU:          state_d = S_GETB;
                    OPC_LDR, OPC_STR: state_d = S_ADDR;
                    OPC_BX:           state_d = (f.op == OP_BLX) ? S_LINK : S_BRX;
                    default:          state_d = S_HALT;
                endcase
            end
            S_GETB: state_d = S_ALU;
            // CMP only updates the flags, so it never reaches the writeback state.
            S_ALU:  state_d = (f.opcode == OPC_ALU && f.op == OP_ALU_CMP) ? S_IF1 : S_WR;
            S_WR:   state_d = S_IF1;
            S_WIMM: state_d = S_IF1;
            S_ADDR: state_d = (f.opcode == OPC_LDR) ? S_MEM : S_GETD;
            S_MEM:  state_d = S_LDW;
            S_LDW:  state_d = S_IF1;
            S_GETD: state_d = S_STW;
            S_STW:  state_d = S_IF1;
            S_LINK: state_d = (f.op == OP_BL) ? S_BR : S_BRX;
            S_BR:   state_d = S_IF1;
            S_BRX:  state_d = S_IF1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        bus.readnum  = 3'b000;
        bus.writenum = 3'b000;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.loadir   = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.msel     = 1'b0;
        bus.mwrite   = 1'b0;
        bus.incp     = 1'b0;
        bus.execb    = 1'b0;
        bus.tsel     = 1'b0;
        bus.vsel     = VSEL_C;
        bus.cond     = 3'b000;
        bus.ALUop    = f.op;
        bus.shift    = f.shift;
        bus.sximm5   = f.sximm5;
        bus.sximm8   = f.sximm8;
        bus.pcreset  = 1'b0;
        bus.halted   = 1'b0;
        case (state_q)
            S_RST:  bus.pcreset = 1'b1;
            S_IF2:  bus.loadir  = 1'b1;
            S_UPC:  bus.incp    = 1'b1;
            S_WIMM: begin
                bus.vsel     = VSEL_IMM;
                bus.writenum = f.rn;
                bus.write    = 1'b1;
            end
            // Branch-through-register reads Rd; everything else reads Rn as the A operand.
            S_GETA: begin
                bus.readnum = (f.opcode == OPC_BX) ? f.rd : f.rn;
                bus.loada   = 1'b1;
            end
            S_GETB: begin
                bus.readnum = f.rm;
                bus.loadb   = 1'b1;
            end
            S_ALU: begin
                bus.loadc = 1'b1;
                bus.asel  = (f.opcode == OPC_MOV);
                bus.loads = (f.opcode == OPC_ALU && f.op == OP_ALU_CMP);
            end
            S_WR: begin
                bus.vsel     = VSEL_C;
                bus.writenum = f.rd;
                bus.write    = 1'b1;
            end
            S_ADDR: begin
                bus.bsel  = 1'b1;
                bus.ALUop = 2'b00;
                bus.loadc = 1'b1;
            end
            S_MEM:  bus.msel = 1'b1;
            S_LDW: begin
                bus.msel     = 1'b1;
                bus.vsel     = VSEL_MDATA;
                bus.writenum = f.rd;
                bus.write    = 1'b1;
            end
            S_GETD: begin
                bus.readnum = f.rd;
                bus.loadb   = 1'b1;
            end
            S_STW: begin
                bus.msel   = 1'b1;
                bus.mwrite = 1'b1;
                bus.shift  = 2'b00;
            end
            S_LINK: begin
                bus.vsel     = VSEL_PC;
                bus.writenum = LINK_REG;
                bus.write    = 1'b1;
            end
            S_BR: begin
                bus.execb = 1'b1;
                bus.tsel  = 1'b1;
                bus.cond  = (f.opcode == OPC_BX) ? COND_ALWAYS : f.rn;
            end
            S_BRX: begin
                bus.execb = 1'b1;
                bus.cond  = COND_ALWAYS;
            end
            S_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected strobe vectors are queued
// when an instruction is issued and popped/compared on each falling edge.
module tb_control_fsm;

    typedef struct packed {
        logic       pcreset, halted, write;
        logic [2:0] writenum, readnum;
        logic       loada, loadb, loadc, loads, loadir;
        logic       asel, bsel, msel, mwrite, incp, execb, tsel;
        logic [1:0] vsel;
        logic [2:0] cond;
        logic [1:0] alu_op, shift;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    ctl_t exp_q[$];
    string tag_q[$];

    control_fsm_if bus ();

    control_fsm #(.LINK_REG(3'd7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t base(input logic [15:0] ir);
        ctl_t c = '0;
        c.alu_op = ir[12:11];
        c.shift  = ir[4:3];
        return c;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c.pcreset = bus.pcreset;  c.halted = bus.halted;  c.write = bus.write;
        c.writenum = bus.writenum; c.readnum = bus.readnum;
        c.loada = bus.loada; c.loadb = bus.loadb; c.loadc = bus.loadc;
        c.loads = bus.loads; c.loadir = bus.loadir;
        c.asel = bus.asel; c.bsel = bus.bsel; c.msel = bus.msel; c.mwrite = bus.mwrite;
        c.incp = bus.incp; c.execb = bus.execb; c.tsel = bus.tsel;
        c.vsel = bus.vsel; c.cond = bus.cond; c.alu_op = bus.ALUop; c.shift = bus.shift;
        return c;
    endfunction

    task automatic push(input string tag, input ctl_t c);
        tag_q.push_back(tag);
        exp_q.push_back(c);
    endtask

    task automatic push_fetch(input logic [15:0] ir);
        ctl_t c;
        c = base(ir);              push("IF1", c);
        c = base(ir); c.loadir = 1; push("IF2", c);
        c = base(ir); c.incp = 1;   push("UPC", c);
        c = base(ir);              push("DEC", c);
    endtask

    task automatic check_next();
        string t;
        ctl_t  e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, 32'(sample()), 32'(e));
        end
    endtask

    // Drive IR right after the edge that enters IF1, then drain the queue one cycle at a time.
    task automatic issue(input logic [15:0] ir);
        int n;
        @(posedge clk);
        #1 bus.IRout = ir;
        n = exp_q.size();
        repeat (n) begin
            @(negedge clk);
            check_next();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t        c;
        logic [15:0] ir;

        bus.IRout  = 16'h0000;
        bus.status = 3'b000;
        reset      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            c = base(16'h0000); c.pcreset = 1; push("RST", c);
            @(negedge clk);
            check_next();
        end
        reset = 1'b1;

        // MOV R3,#-2
        ir = 16'hD3FE; push_fetch(ir);
        c = base(ir); c.vsel = 2'b10; c.writenum = 3'd3; c.write = 1; push("MOV_WIMM", c);
        issue(ir);
        chk("MOV_sximm8", 32'(bus.sximm8), 32'h0000_FFFE);

        // ADD R5,R1,R3 with shift field 11 and negative imm5
        ir = 16'hA1BB; push_fetch(ir);
        c = base(ir); c.readnum = 3'd1; c.loada = 1; push("ADD_GETA", c);
        c = base(ir); c.readnum = 3'd3; c.loadb = 1; push("ADD_GETB", c);
        c = base(ir); c.loadc = 1; push("ADD_ALU", c);
        c = base(ir); c.writenum = 3'd5; c.write = 1; push("ADD_WR", c);
        issue(ir);
        chk("ADD_sximm5", 32'(bus.sximm5), 32'h0000_FFFB);

        // CMP R1,R2
        ir = 16'hA902; push_fetch(ir);
        c = base(ir); c.readnum = 3'd1; c.loada = 1; push("CMP_GETA", c);
        c = base(ir); c.readnum = 3'd2; c.loadb = 1; push("CMP_GETB", c);
        c = base(ir); c.loadc = 1; c.loads = 1; push("CMP_ALU", c);
        issue(ir);

        // MOV R5,R3
        ir = 16'hC0A3; push_fetch(ir);
        c = base(ir); c.readnum = 3'd3; c.loadb = 1; push("MOVR_GETB", c);
        c = base(ir); c.loadc = 1; c.asel = 1; push("MOVR_ALU", c);
        c = base(ir); c.writenum = 3'd5; c.write = 1; push("MOVR_WR", c);
        issue(ir);

        // STR R2,[R0,#1]
        ir = 16'h8041; push_fetch(ir);
        c = base(ir); c.readnum = 3'd0; c.loada = 1; push("STR_GETA", c);
        c = base(ir); c.bsel = 1; c.loadc = 1; c.alu_op = 2'b00; push("STR_ADDR", c);
        c = base(ir); c.readnum = 3'd2; c.loadb = 1; push("STR_GETD", c);
        c = base(ir); c.msel = 1; c.mwrite = 1; c.shift = 2'b00; push("STR_STW", c);
        issue(ir);

        // LDR R2,[R0,#1]
        ir = 16'h6041; push_fetch(ir);
        c = base(ir); c.readnum = 3'd0; c.loada = 1; push("LDR_GETA", c);
        c = base(ir); c.bsel = 1; c.loadc = 1; c.alu_op = 2'b00; push("LDR_ADDR", c);
        c = base(ir); c.msel = 1; push("LDR_MEM", c);
        c = base(ir); c.msel = 1; c.vsel = 2'b11; c.writenum = 3'd2; c.write = 1; push("LDR_LDW", c);
        issue(ir);

        // BLT #5 with N=1,V=0
        bus.status = 3'b010;
        ir = 16'h2305; push_fetch(ir);
        c = base(ir); c.execb = 1; c.tsel = 1; c.cond = 3'b011; push("BLT_BR", c);
        issue(ir);

        // BL #3
        ir = 16'h5F03; push_fetch(ir);
        c = base(ir); c.vsel = 2'b01; c.writenum = 3'd7; c.write = 1; push("BL_LINK", c);
        c = base(ir); c.execb = 1; c.tsel = 1; c.cond = 3'b111; push("BL_BR", c);
        issue(ir);

        // BX R2
        ir = 16'h4040; push_fetch(ir);
        c = base(ir); c.readnum = 3'd2; c.loada = 1; push("BX_GETA", c);
        c = base(ir); c.execb = 1; c.cond = 3'b111; push("BX_BRX", c);
        issue(ir);

        // BLX R7: Rd read before the link write
        ir = 16'h50E0; push_fetch(ir);
        c = base(ir); c.readnum = 3'd7; c.loada = 1; push("BLX_GETA", c);
        c = base(ir); c.vsel = 2'b01; c.writenum = 3'd7; c.write = 1; push("BLX_LINK", c);
        c = base(ir); c.execb = 1; c.cond = 3'b111; push("BLX_BRX", c);
        issue(ir);

        // HALT, stays halted, then asynchronous reset mid-cycle
        ir = 16'hE000; push_fetch(ir);
        for (int i = 0; i < 3; i++) begin
            c = base(ir); c.halted = 1; push("HALT", c);
        end
        issue(ir);
        #2 reset = 1'b0;
        c = base(ir); c.pcreset = 1; push("ASYNC_RST", c);
        #1 check_next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
